// File: rtl/ram_port_arbiter_pkg.sv
// Shared constants and request payload type for the RAM port arbiter.
package tachyon_ram_arb_pkg;

    localparam int unsigned PORT_DBG = 0;
    localparam int unsigned PORT_LSU = 1;
    localparam int unsigned PORT_IFU = 2;
    localparam int unsigned NR_PORTS = 3;

    localparam int unsigned RAM_ADDR_WIDTH  = 18;
    localparam int unsigned RAM_DATA_WIDTH  = 32;
    localparam int unsigned RAM_WADDR_WIDTH = RAM_ADDR_WIDTH - 2;
    localparam int unsigned RAM_BE_WIDTH    = RAM_DATA_WIDTH / 8;

    typedef struct packed {
        logic                       we;
        logic [RAM_WADDR_WIDTH-1:0] addr;
        logic [RAM_DATA_WIDTH-1:0]  wdata;
        logic [RAM_BE_WIDTH-1:0]    be;
    } ram_req_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Master-side request/response bundle of the RAM port arbiter.
interface ram_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 18,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NR_PORTS   = 3
);
    localparam int unsigned WADDR_WIDTH = ADDR_WIDTH - 2;
    localparam int unsigned BE_WIDTH    = DATA_WIDTH / 8;

    logic [NR_PORTS-1:0]                  req_valid;
    logic [NR_PORTS-1:0]                  req_lock;
    logic [NR_PORTS-1:0]                  req_we;
    logic [NR_PORTS-1:0][WADDR_WIDTH-1:0] req_addr;
    logic [NR_PORTS-1:0][DATA_WIDTH-1:0]  req_wdata;
    logic [NR_PORTS-1:0][BE_WIDTH-1:0]    req_be;
    logic [NR_PORTS-1:0]                  req_ready;
    logic [NR_PORTS-1:0]                  rsp_valid;
    logic [DATA_WIDTH-1:0]                rsp_rdata;

    modport master (
        output req_valid, req_lock, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_lock, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/ram_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr wins (one-hot).
module ram_arb_rr_pick #(
    parameter  int unsigned NR_PORTS  = 3,
    localparam int unsigned PTR_WIDTH = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1
) (
    input  logic [NR_PORTS-1:0]  req,
    input  logic [PTR_WIDTH-1:0] ptr,
    output logic [NR_PORTS-1:0]  grant
);
    import tachyon_ram_arb_pkg::*;

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NR_PORTS; i++) begin
            if (!found && req[PTR_WIDTH'((32'(ptr) + i) % NR_PORTS)]) begin
                grant[PTR_WIDTH'((32'(ptr) + i) % NR_PORTS)] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single-port program/data RAM between debug, LSU and IFU masters.
// Optional build macro RAM_ARB_DBG_PRIO_EN gives the debug port priority over round-robin.
module ram_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 18,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NR_PORTS   = 3,
    parameter int unsigned MAX_WAIT   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    ram_port_arbiter_if.slave       bus,
    output logic                    ram_en,
    output logic                    ram_we,
    output logic [ADDR_WIDTH-3:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_wdata,
    output logic [DATA_WIDTH/8-1:0] ram_be,
    input  logic [DATA_WIDTH-1:0]   ram_rdata,
    output logic [NR_PORTS-1:0]     starve
);
    import tachyon_ram_arb_pkg::*;

    localparam int unsigned PTR_WIDTH = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
    localparam int unsigned CNT_WIDTH = $clog2(MAX_WAIT + 1);

    logic [PTR_WIDTH-1:0] rr_ptr;
    logic [PTR_WIDTH-1:0] lock_port;
    logic                 lock_q;
    logic [PTR_WIDTH-1:0] win_idx;
    logic [NR_PORTS-1:0]  rr_grant;
    logic [NR_PORTS-1:0]  grant;
    logic                 rr_win;
    logic [NR_PORTS-1:0]  rsp_valid_q;
    logic                 rsp_we_q;
    logic [CNT_WIDTH-1:0] wait_cnt [NR_PORTS];
    logic [NR_PORTS-1:0]  starve_q;

    ram_arb_rr_pick #(.NR_PORTS(NR_PORTS)) u_rr_pick (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (rr_grant)
    );

    // Winner: live lock, then optional debug priority, then round-robin.
    always_comb begin
        grant  = '0;
        rr_win = 1'b0;
        if (!rst) begin
            if (lock_q && bus.req_valid[lock_port]) begin
                grant[lock_port] = 1'b1;
            end
`ifdef RAM_ARB_DBG_PRIO_EN
            else if (bus.req_valid[PTR_WIDTH'(PORT_DBG)]) begin
                grant[PTR_WIDTH'(PORT_DBG)] = 1'b1;
            end
`endif
            else begin
                grant  = rr_grant;
                rr_win = |rr_grant;
            end
        end
    end

    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < NR_PORTS; i++) begin
            if (grant[i]) win_idx = PTR_WIDTH'(i);
        end
    end

    assign ram_en    = |grant;
    assign ram_we    = ram_en & bus.req_we[win_idx];
    assign ram_addr  = bus.req_addr[win_idx];
    assign ram_wdata = bus.req_wdata[win_idx];
    assign ram_be    = bus.req_be[win_idx];

    // A response still in flight when reset arrives is suppressed at once.
    assign bus.req_ready = grant;
    assign bus.rsp_valid = rst ? '0 : rsp_valid_q;
    assign bus.rsp_rdata = (!rst && (|rsp_valid_q) && !rsp_we_q) ? ram_rdata : '0;
    assign starve        = starve_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            lock_q      <= 1'b0;
            lock_port   <= '0;
            rsp_valid_q <= '0;
            rsp_we_q    <= 1'b0;
        end else begin
            rsp_valid_q <= grant;
            rsp_we_q    <= ram_we;
            lock_q      <= ram_en & bus.req_lock[win_idx];
            if (ram_en) lock_port <= win_idx;
            if (rr_win) begin
                rr_ptr <= (win_idx == PTR_WIDTH'(NR_PORTS - 1)) ? '0 : win_idx + PTR_WIDTH'(1);
            end
        end
    end

    // Per-master wait counters; starve latches as a counter reaches MAX_WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NR_PORTS; k++) wait_cnt[k] <= '0;
            starve_q <= '0;
        end else begin
            for (int unsigned k = 0; k < NR_PORTS; k++) begin
                if (grant[k]) begin
                    wait_cnt[k] <= '0;
                end else if (bus.req_valid[k] && (wait_cnt[k] != CNT_WIDTH'(MAX_WAIT))) begin
                    wait_cnt[k] <= wait_cnt[k] + CNT_WIDTH'(1);
                    if (wait_cnt[k] == CNT_WIDTH'(MAX_WAIT - 1)) starve_q[k] <= 1'b1;
                end
            end
        end
    end

endmodule
